// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
//   Schedules NUM_VOICES synth voices among incoming MIDI note events.
//   Note-on policy: retrigger the voice already gated on the same note,
//   else take the first free voice, else steal the oldest voice.
//   Each event takes NUM_VOICES+1 cycles after its handshake edge:
//   one cycle per voice examined, plus one commit cycle.
//
// Parameters:
//   NUM_VOICES  number of voices (2..16)
//   AGE_BITS    width of the saturating per-voice age counter
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ev_valid        event offered
//   ev_ready        event accepted when high (IDLE only)
//   ev_note_on      1 = note-on, 0 = note-off (velocity 0 also means off)
//   ev_note         MIDI note number
//   ev_velocity     MIDI velocity
//   sustain         CC64 state (only with VOICE_ALLOC_SUSTAIN_EN)
//   voice_gate      per-voice gate
//   voice_note      packed, voice i at [7i+6:7i]
//   voice_velocity  packed, same layout as voice_note
//   voice_trigger   one-cycle pulse on note-on assignment
//   busy            ~ev_ready
//
// Optional feature macro: VOICE_ALLOC_SUSTAIN_EN (sustain pedal handling).

module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_note_on,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_velocity,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                    sustain,
`endif
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic [NUM_VOICES-1:0]   voice_trigger,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0]       LAST_IDX = IW'(NUM_VOICES - 1);
  localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;

  logic [1:0]          r_state;
  logic [IW-1:0]       r_idx;

  // latched event
  logic                r_on;
  logic [6:0]          r_note;
  logic [6:0]          r_vel;

  // per-voice state
  logic [NUM_VOICES-1:0] r_gate;
  logic [NUM_VOICES-1:0] r_trig;
  logic [6:0]            r_vnote [NUM_VOICES];
  logic [6:0]            r_vvel  [NUM_VOICES];
  logic [AGE_BITS-1:0]   r_age   [NUM_VOICES];

  // scan results
  logic                r_match_found;
  logic [IW-1:0]       r_match_idx;
  logic                r_free_found;
  logic [IW-1:0]       r_free_idx;
  logic [IW-1:0]       r_old_idx;
  logic [AGE_BITS-1:0] r_old_age;

  logic                w_cur_gate;
  logic [6:0]          w_cur_note;
  logic [AGE_BITS-1:0] w_cur_age;
  logic [IW-1:0]       w_target;
  logic                w_ready;

  assign w_cur_gate = r_gate[r_idx];
  assign w_cur_note = r_vnote[r_idx];
  assign w_cur_age  = r_age[r_idx];

  assign w_target = r_match_found ? r_match_idx :
                    r_free_found  ? r_free_idx  : r_old_idx;

`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic                  r_sus_q;
  logic                  r_rel_pend;
  logic [NUM_VOICES-1:0] r_sus_flag;
  logic                  w_fall;
  logic                  w_release;

  assign w_fall    = r_sus_q & ~sustain;
  // Pedal release is latched and executed in the first IDLE cycle, where it
  // blocks the handshake; ev_ready therefore depends only on registers.
  assign w_release = (r_state == S_IDLE) && r_rel_pend;
  assign w_ready   = (r_state == S_IDLE) && !r_rel_pend;
`else
  assign w_ready   = (r_state == S_IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_on          <= 1'b0;
      r_note        <= '0;
      r_vel         <= '0;
      r_gate        <= '0;
      r_trig        <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_vnote[i] <= '0;
        r_vvel[i]  <= '0;
        r_age[i]   <= '0;
      end
`ifdef VOICE_ALLOC_SUSTAIN_EN
      r_sus_q    <= 1'b0;
      r_rel_pend <= 1'b0;
      r_sus_flag <= '0;
`endif
    end else begin
      r_trig <= '0;

      case (r_state)
        S_IDLE: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
          if (w_release) begin
            r_gate     <= r_gate & ~r_sus_flag;
            r_sus_flag <= '0;
          end else
`endif
          if (ev_valid) begin
            r_on          <= ev_note_on && (ev_velocity != 7'd0);
            r_note        <= ev_note;
            r_vel         <= ev_velocity;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_state       <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_cur_gate && (w_cur_note == r_note) && !r_match_found) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!w_cur_gate && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          // strict compare keeps the lowest index on equal ages
          if ((r_idx == '0) || (w_cur_age > r_old_age)) begin
            r_old_idx <= r_idx;
            r_old_age <= w_cur_age;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_COMMIT;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end

        S_COMMIT: begin
          r_state <= S_IDLE;
          if (r_on) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              if (IW'(i) == w_target) begin
                r_gate[i]  <= 1'b1;
                r_vnote[i] <= r_note;
                r_vvel[i]  <= r_vel;
                r_age[i]   <= '0;
                r_trig[i]  <= 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                r_sus_flag[i] <= 1'b0;
`endif
              end else if (r_gate[i] && (r_age[i] != AGE_MAX)) begin
                r_age[i] <= r_age[i] + AGE_BITS'(1);
              end
            end
          end else if (r_match_found) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
            if (sustain) begin
              r_sus_flag[r_match_idx] <= 1'b1;
            end else begin
              r_gate[r_match_idx]     <= 1'b0;
              r_sus_flag[r_match_idx] <= 1'b0;
            end
`else
            r_gate[r_match_idx] <= 1'b0;
`endif
          end
        end

        default: r_state <= S_IDLE;
      endcase

`ifdef VOICE_ALLOC_SUSTAIN_EN
      r_sus_q <= sustain;
      if (w_fall) begin
        r_rel_pend <= 1'b1;
      end else if (w_release) begin
        r_rel_pend <= 1'b0;
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7]     = r_vnote[g];
    assign voice_velocity[7*g +: 7] = r_vvel[g];
  end

  assign voice_gate    = r_gate;
  assign voice_trigger = r_trig;
  assign ev_ready      = w_ready;
  assign busy          = ~w_ready;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator
//   Directed bench for midi_voice_allocator with NUM_VOICES=4.
//   Define VOICE_ALLOC_SUSTAIN_EN for both files to cover the sustain pedal.

module tb_midi_voice_allocator;

  localparam int NV = 4;

  logic          clk;
  logic          rst;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_note_on;
  logic [6:0]    ev_note;
  logic [6:0]    ev_velocity;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic          sustain;
`endif
  logic [NV-1:0]   voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_velocity;
  logic [NV-1:0]   voice_trigger;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  midi_voice_allocator #(.NUM_VOICES(NV), .AGE_BITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_note_on     (ev_note_on),
    .ev_note        (ev_note),
    .ev_velocity    (ev_velocity),
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .sustain        (sustain),
`endif
    .voice_gate     (voice_gate),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .voice_trigger  (voice_trigger),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g,
                           input logic [27:0] notes, input logic [27:0] vels);
    chk({tag, "_gate"}, voice_gate, g);
    chk({tag, "_note"}, voice_note, notes);
    chk({tag, "_vel"},  voice_velocity, vels);
  endtask

  // Offers one event, checks ev_ready/busy low and trigger quiet for the
  // whole latency, then checks the trigger pulse and that it lasts one cycle.
  task automatic send(input string tag, input logic on, input logic [6:0] note,
                      input logic [6:0] vel, input logic [3:0] exp_trig);
    int cnt;
    cnt = 0;
    while (!ev_ready && cnt < 50) begin
      step();
      cnt++;
    end
    chk({tag, "_ready_wait"}, ev_ready, 1'b1);
    ev_valid    = 1'b1;
    ev_note_on  = on;
    ev_note     = note;
    ev_velocity = vel;
    step();                       // handshake edge E
    ev_valid = 1'b0;
    chk({tag, "_ready_low"}, ev_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk({tag, "_ready_low"}, ev_ready, 1'b0);
      chk({tag, "_trig_quiet"}, voice_trigger, 4'b0000);
    end
    step();                       // E+5
    chk({tag, "_ready_back"}, ev_ready, 1'b1);
    chk({tag, "_trig"}, voice_trigger, exp_trig);
    step();
    chk({tag, "_trig_clear"}, voice_trigger, 4'b0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  int cnt;

  initial begin
    rst         = 1'b1;
    ev_valid    = 1'b0;
    ev_note_on  = 1'b0;
    ev_note     = '0;
    ev_velocity = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain     = 1'b0;
`endif
    step();
    chk("reset_ready", ev_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_trig", voice_trigger, 4'b0000);
    chk_state("reset", 4'b0000, '0, '0);
    rst = 1'b0;
    step();

    // ---- 1: reset mid-scan discards the pending event
    send("t1_pre", 1'b1, 7'd40, 7'd20, 4'b0001);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd41; ev_velocity = 7'd21;
    step();
    ev_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("t1_rst_ready", ev_ready, 1'b1);
    chk("t1_rst_trig", voice_trigger, 4'b0000);
    chk_state("t1_rst", 4'b0000, '0, '0);
    step();
    rst = 1'b0;
    repeat (7) step();
    chk_state("t1_discard", 4'b0000, '0, '0);
    send("t1_on60", 1'b1, 7'd60, 7'd100, 4'b0001);
    chk_state("t1_on60", 4'b0001, {7'd0, 7'd0, 7'd0, 7'd60}, {7'd0, 7'd0, 7'd0, 7'd100});

    // ---- 2: fill and steal oldest
    send("t2_on62", 1'b1, 7'd62, 7'd100, 4'b0010);
    send("t2_on64", 1'b1, 7'd64, 7'd100, 4'b0100);
    send("t2_on65", 1'b1, 7'd65, 7'd100, 4'b1000);
    chk_state("t2_full", 4'b1111, {7'd65, 7'd64, 7'd62, 7'd60}, {4{7'd100}});
    send("t2_on67", 1'b1, 7'd67, 7'd70, 4'b0001);
    chk_state("t2_steal0", 4'b1111, {7'd65, 7'd64, 7'd62, 7'd67},
              {7'd100, 7'd100, 7'd100, 7'd70});
    send("t2_on69", 1'b1, 7'd69, 7'd71, 4'b0010);
    chk_state("t2_steal1", 4'b1111, {7'd65, 7'd64, 7'd69, 7'd67},
              {7'd100, 7'd100, 7'd71, 7'd70});

    // ---- 3: note-off holds note, free voice beats older gated voices
    do_reset();
    send("t3_on60", 1'b1, 7'd60, 7'd100, 4'b0001);
    send("t3_on62", 1'b1, 7'd62, 7'd100, 4'b0010);
    send("t3_on64", 1'b1, 7'd64, 7'd100, 4'b0100);
    send("t3_on65", 1'b1, 7'd65, 7'd100, 4'b1000);
    send("t3_off62", 1'b0, 7'd62, 7'd64, 4'b0000);
    chk_state("t3_off62", 4'b1101, {7'd65, 7'd64, 7'd62, 7'd60}, {4{7'd100}});
    send("t3_on71", 1'b1, 7'd71, 7'd80, 4'b0010);
    chk_state("t3_on71", 4'b1111, {7'd65, 7'd64, 7'd71, 7'd60},
              {7'd100, 7'd100, 7'd80, 7'd100});

    // ---- 4: retrigger same note, then velocity-0 note-off
    send("t4_re64", 1'b1, 7'd64, 7'd90, 4'b0100);
    chk_state("t4_re64", 4'b1111, {7'd65, 7'd64, 7'd71, 7'd60},
              {7'd100, 7'd90, 7'd80, 7'd100});
    send("t4_v0", 1'b1, 7'd64, 7'd0, 4'b0000);
    chk_state("t4_v0", 4'b1011, {7'd65, 7'd64, 7'd71, 7'd60},
              {7'd100, 7'd90, 7'd80, 7'd100});

    // ---- 5: back-to-back with ev_valid held high
    // ages now v0=5 v1=1 v3=2 (v2 free): 72 -> v2, 74 steals v0, off 71 -> v1
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd72; ev_velocity = 7'd50;
    step();
    ev_note = 7'd74; ev_velocity = 7'd51;
    cnt = 0;
    while (!ev_ready && cnt < 20) begin cnt++; step(); end
    chk("t5_a_ready_cycles", cnt, 5);
    chk("t5_a_trig", voice_trigger, 4'b0100);
    step();
    ev_note_on = 1'b0; ev_note = 7'd71; ev_velocity = 7'd0;
    cnt = 0;
    while (!ev_ready && cnt < 20) begin cnt++; step(); end
    chk("t5_b_ready_cycles", cnt, 5);
    chk("t5_b_trig", voice_trigger, 4'b0001);
    step();
    ev_valid = 1'b0;
    cnt = 0;
    while (!ev_ready && cnt < 20) begin cnt++; step(); end
    chk("t5_c_ready_cycles", cnt, 5);
    chk("t5_c_trig", voice_trigger, 4'b0000);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ev_ready && voice_trigger == 4'b0000) cnt++;
    end
    chk("t5_no_extra", cnt, 8);
    chk_state("t5_bb", 4'b1101, {7'd65, 7'd72, 7'd71, 7'd74},
              {7'd100, 7'd50, 7'd80, 7'd51});
    send("t5_off50", 1'b0, 7'd50, 7'd30, 4'b0000);
    chk_state("t5_off50", 4'b1101, {7'd65, 7'd72, 7'd71, 7'd74},
              {7'd100, 7'd50, 7'd80, 7'd51});

`ifdef VOICE_ALLOC_SUSTAIN_EN
    // ---- 6: sustain pedal
    do_reset();
    sustain = 1'b1;
    step();
    send("t6_on60", 1'b1, 7'd60, 7'd100, 4'b0001);
    send("t6_off60", 1'b0, 7'd60, 7'd64, 4'b0000);
    chk("t6_held", voice_gate, 4'b0001);
    sustain = 1'b0;
    step();
    chk("t6_rel_ready", ev_ready, 1'b0);
    chk("t6_rel_gate_pre", voice_gate, 4'b0001);
    step();
    chk("t6_rel_gate", voice_gate, 4'b0000);
    chk("t6_rel_ready_back", ev_ready, 1'b1);

    sustain = 1'b1;
    step();
    send("t6_on62", 1'b1, 7'd62, 7'd100, 4'b0001);
    send("t6_off62", 1'b0, 7'd62, 7'd64, 4'b0000);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd70; ev_velocity = 7'd90;
    step();
    ev_valid = 1'b0;
    step();
    sustain = 1'b0;
    step();
    chk("t6_defer_scan_gate", voice_gate, 4'b0001);
    cnt = 0;
    while (voice_trigger == 4'b0000 && cnt < 10) begin cnt++; step(); end
    chk("t6_defer_trig", voice_trigger, 4'b0010);
    chk("t6_defer_commit_gate", voice_gate, 4'b0011);
    chk("t6_defer_ready", ev_ready, 1'b0);
    step();
    chk("t6_defer_rel_gate", voice_gate, 4'b0010);
    chk("t6_defer_rel_ready", ev_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
